// File: rtl/onewire_pkg.sv
// Shared one-wire definitions: engine command codes and the bus arbiter state
// encoding. Sensor controllers import this package too, so the command codes
// they drive onto the arbiter's cmd lanes match the codes decoded here.
package onewire_pkg;

  // Command codes carried on each requester's 2-bit cmd lane.
  typedef enum logic [1:0] {
    OW_CMD_RESET   = 2'd0,
    OW_CMD_WRITE   = 2'd1,
    OW_CMD_READ    = 2'd2,
    OW_CMD_RELEASE = 2'd3
  } owCmd_e;

  // Bus arbiter states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWNED  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } arbState_e;

endpackage

// File: rtl/rr_pick_onehot.sv
// Round-robin picker. Returns a one-hot grant for the first asserted request
// found when scanning upward from the requester after lastOwner, wrapping
// around. An empty req vector gives an all-zero grant.
//   req       : request vector
//   lastOwner : index of the most recent bus owner
//   grant     : one-hot winner (or zero)
module rr_pick_onehot #(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] lastOwner,
  output logic [N-1:0]  grant
);

  logic [LW:0] sum;

  // Scan from the farthest candidate to the nearest so the nearest asserted
  // request overwrites any earlier hit.
  always_comb begin
    grant = '0;
    sum   = '0;
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, lastOwner} + (LW+1)'(k);
      if (sum >= (LW+1)'(N)) sum = sum - (LW+1)'(N);
      if (req[sum[LW-1:0]]) begin
        grant                 = '0;
        grant[sum[LW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onewire_bus_arbiter.sv
// One-wire bus arbiter. Shares a single one-wire byte engine between N_REQ
// requesters: grants the bus round-robin, forwards the owner's reset/write/
// read command to the engine as a level strobe held until the engine reports
// busy, waits for the engine to finish, and pulses done (or err on a strobe
// that never raised busy).
//   CLK_10MHZ, RST_N      : clock, synchronous active-low reset
//   req/grant             : per-requester level request, one-hot ownership
//   cmd/cmd_valid/wr_byte : per-requester command lanes (2/1/8 bits each)
//   cmd_ready             : owner's command is accepted this cycle
//   rd_byte               : byte from the last completed read
//   done/err              : one-cycle completion / timeout pulses
//   ow_reset/write/read   : engine strobes, ow_in_byte byte to engine
//   ow_out_byte, ow_busy  : engine result byte and (asynchronous) busy
module onewire_bus_arbiter
  import onewire_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int STROBE_TIMEOUT = 1200
) (
  input  logic               CLK_10MHZ,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   grant,
  input  logic [2*N_REQ-1:0] cmd,
  input  logic [N_REQ-1:0]   cmd_valid,
  output logic               cmd_ready,
  input  logic [8*N_REQ-1:0] wr_byte,
  output logic [7:0]         rd_byte,
  output logic               done,
  output logic               err,
  output logic               ow_reset,
  output logic               ow_write,
  output logic               ow_read,
  output logic [7:0]         ow_in_byte,
  input  logic [7:0]         ow_out_byte,
  input  logic               ow_busy
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(STROBE_TIMEOUT + 1);

  arbState_e        state, stateNxt;
  owCmd_e           cmdLat, cmdNxt;
  logic [LW-1:0]    lastOwner, lastNxt;
  logic [N_REQ-1:0] grantNxt, pickGrant;
  logic [7:0]       inByteNxt, rdNxt;
  logic             doneNxt, errNxt;
  logic [CW-1:0]    toCnt, cntNxt;

  // busy comes from the engine's divided clock domain.
  logic busyS1, busyS2, busyD;
  logic busyRise, busyFall;

  // Owner's lanes, selected by the one-hot grant.
  logic [LW-1:0] ownerIdx;
  logic [1:0]    ownCmd;
  logic          ownValid, ownReq;
  logic [7:0]    ownByte;

  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      busyS1 <= 1'b0;
      busyS2 <= 1'b0;
      busyD  <= 1'b0;
    end else begin
      busyS1 <= ow_busy;
      busyS2 <= busyS1;
      busyD  <= busyS2;
    end
  end

  assign busyRise = busyS2 & ~busyD;
  assign busyFall = ~busyS2 & busyD;

  rr_pick_onehot #(.N(N_REQ), .LW(LW)) uPick (
    .req       (req),
    .lastOwner (lastOwner),
    .grant     (pickGrant)
  );

  always_comb begin
    ownerIdx = '0;
    ownCmd   = '0;
    ownValid = 1'b0;
    ownReq   = 1'b0;
    ownByte  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        ownerIdx = LW'(i);
        ownCmd   = cmd[2*i +: 2];
        ownValid = cmd_valid[i];
        ownReq   = req[i];
        ownByte  = wr_byte[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      state      <= IDLE;
      grant      <= '0;
      lastOwner  <= LW'(N_REQ - 1);
      cmdLat     <= OW_CMD_RESET;
      ow_in_byte <= '0;
      rd_byte    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      toCnt      <= '0;
    end else begin
      state      <= stateNxt;
      grant      <= grantNxt;
      lastOwner  <= lastNxt;
      cmdLat     <= cmdNxt;
      ow_in_byte <= inByteNxt;
      rd_byte    <= rdNxt;
      done       <= doneNxt;
      err        <= errNxt;
      toCnt      <= cntNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    grantNxt  = grant;
    lastNxt   = lastOwner;
    cmdNxt    = cmdLat;
    inByteNxt = ow_in_byte;
    rdNxt     = rd_byte;
    doneNxt   = 1'b0;
    errNxt    = 1'b0;
    cntNxt    = toCnt;
    cmd_ready = (state == OWNED) && !busyS2;
    ow_reset  = 1'b0;
    ow_write  = 1'b0;
    ow_read   = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          grantNxt = pickGrant;
          stateNxt = OWNED;
        end
      end
      OWNED: begin
        // A dropped request releases the bus even while the engine is busy.
        if (!ownReq || (cmd_ready && ownValid && ownCmd == OW_CMD_RELEASE)) begin
          grantNxt = '0;
          lastNxt  = ownerIdx;
          stateNxt = IDLE;
        end else if (cmd_ready && ownValid) begin
          cmdNxt    = owCmd_e'(ownCmd);
          inByteNxt = ownByte;
          cntNxt    = '0;
          stateNxt  = STROBE;
        end
      end
      STROBE: begin
        ow_reset = (cmdLat == OW_CMD_RESET);
        ow_write = (cmdLat == OW_CMD_WRITE);
        ow_read  = (cmdLat == OW_CMD_READ);
        // busy seen on the last timeout cycle still counts as an accept.
        if (busyRise) begin
          stateNxt = WAIT;
        end else if (toCnt == CW'(STROBE_TIMEOUT - 1)) begin
          errNxt   = 1'b1;
          stateNxt = OWNED;
        end else begin
          cntNxt = toCnt + CW'(1);
        end
      end
      WAIT: begin
        if (busyFall) begin
          if (cmdLat == OW_CMD_READ) rdNxt = ow_out_byte;
          stateNxt = FINISH;
        end
      end
      FINISH: begin
        doneNxt  = 1'b1;
        stateNxt = OWNED;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_onewire_bus_arbiter.sv
module tb_onewire_bus_arbiter;
  import onewire_pkg::*;

  localparam int N  = 2;
  localparam int TO = 1200;

  logic         CLK_10MHZ = 1'b0;
  logic         RST_N;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [2*N-1:0] cmd;
  logic [N-1:0] cmd_valid;
  logic         cmd_ready;
  logic [8*N-1:0] wr_byte;
  logic [7:0]   rd_byte;
  logic         done, err, ow_reset, ow_write, ow_read;
  logic [7:0]   ow_in_byte, ow_out_byte;
  logic         ow_busy;
  logic [2:0]   stb;

  assign stb = {ow_read, ow_write, ow_reset};

  onewire_bus_arbiter #(.N_REQ(N), .STROBE_TIMEOUT(TO)) dut (
    .CLK_10MHZ(CLK_10MHZ), .RST_N(RST_N), .req(req), .grant(grant),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_byte(wr_byte), .rd_byte(rd_byte), .done(done), .err(err),
    .ow_reset(ow_reset), .ow_write(ow_write), .ow_read(ow_read),
    .ow_in_byte(ow_in_byte), .ow_out_byte(ow_out_byte), .ow_busy(ow_busy)
  );

  always #5 CLK_10MHZ = ~CLK_10MHZ;

  int nVec = 0;
  int nMis = 0;
  logic [7:0] rdModel = 8'h00;
  int lastModel = N - 1;

  typedef struct {
    logic [1:0] rq;
    logic [1:0] cv;
    logic [3:0] cm;
    logic [1:0] eGrant;
    logic       eReady;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_10MHZ);
    #1;
    chk("strobeOneHot", 32'($countones(stb) <= 1), 32'd1);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'd0);
    chk({tag, ".ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".strobes"}, 32'(stb), 32'd0);
    chk({tag, ".inByte"}, 32'(ow_in_byte), 32'd0);
    chk({tag, ".rdByte"}, 32'(rd_byte), 32'd0);
  endtask

  // Issue one command from owner `own` and play the engine side.
  task automatic doCmd(input int own, input logic [1:0] c, input logic [7:0] b,
                       input int delay, input int len, input logic [7:0] ret,
                       input bit noBusy);
    int  i;
    bit  sawDone;
    cmd_valid = '0;
    cmd_valid[own] = 1'b1;
    cmd[2*own +: 2] = c;
    wr_byte[8*own +: 8] = b;
    tick();
    cmd_valid = '0;
    chk("strobeKind", 32'(stb), 32'(3'b001 << c));
    chk("inByte", 32'(ow_in_byte), 32'(b));
    if (noBusy) begin
      i = 0;
      sawDone = 1'b0;
      while (!err && i < TO + 20) begin
        tick();
        i++;
        if (done) sawDone = 1'b1;
        if (!err && i < TO && stb == 3'b000) sawDone = 1'b1;
      end
      chk("errAtTimeout", 32'(i), 32'(TO));
      chk("noDoneOrEarlyDrop", 32'(sawDone), 32'd0);
      chk("strobeAfterErr", 32'(stb), 32'd0);
      chk("readyAfterErr", 32'(cmd_ready), 32'd1);
      chk("rdKeptOnErr", 32'(rd_byte), 32'(rdModel));
      tick();
      chk("errPulse", 32'(err), 32'd0);
    end else begin
      repeat (delay) tick();
      ow_busy = 1'b1;
      ow_out_byte = ret;
      repeat (len) tick();
      ow_busy = 1'b0;
      i = 0;
      while (!done && !err && i < 20) begin
        tick();
        i++;
      end
      // Two synchronizer flops plus the two-cycle done latency.
      chk("doneLatency", 32'(i), 32'd4);
      chk("noErr", 32'(err), 32'd0);
      if (c == 2'd2) rdModel = ret;
      chk("rdByte", 32'(rd_byte), 32'(rdModel));
      tick();
      chk("donePulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int own, r, exp, nCmd;
    logic [1:0] c;

    RST_N = 1'b0; req = '0; cmd = '0; cmd_valid = '0; wr_byte = '0;
    ow_out_byte = '0; ow_busy = 1'b0;
    tick(); tick();
    chkResetOutputs("reset");
    RST_N = 1'b1;

    // Arbitration table: rotation, release by command and by dropped req,
    // and a non-owner reset command that must be ignored.
    vecs[0]  = '{2'b00, 2'b00, 4'b0000, 2'b00, 1'b0};
    vecs[1]  = '{2'b11, 2'b00, 4'b0000, 2'b01, 1'b1};
    vecs[2]  = '{2'b11, 2'b10, 4'b0000, 2'b01, 1'b1};
    vecs[3]  = '{2'b10, 2'b00, 4'b0000, 2'b00, 1'b0};
    vecs[4]  = '{2'b10, 2'b00, 4'b0000, 2'b10, 1'b1};
    vecs[5]  = '{2'b11, 2'b10, 4'b1100, 2'b00, 1'b0};
    vecs[6]  = '{2'b11, 2'b00, 4'b0000, 2'b01, 1'b1};
    vecs[7]  = '{2'b11, 2'b01, 4'b0011, 2'b00, 1'b0};
    vecs[8]  = '{2'b11, 2'b00, 4'b0000, 2'b10, 1'b1};
    vecs[9]  = '{2'b11, 2'b10, 4'b1100, 2'b00, 1'b0};
    vecs[10] = '{2'b11, 2'b00, 4'b0000, 2'b01, 1'b1};
    for (int v = 0; v < 11; v++) begin
      req = vecs[v].rq; cmd_valid = vecs[v].cv; cmd = vecs[v].cm;
      tick();
      chk($sformatf("tbl%0d.grant", v), 32'(grant), 32'(vecs[v].eGrant));
      chk($sformatf("tbl%0d.ready", v), 32'(cmd_ready), 32'(vecs[v].eReady));
      chk($sformatf("tbl%0d.strobe", v), 32'(stb), 32'd0);
    end
    cmd_valid = '0; cmd = '0;

    // Write 0xCC, engine busy 70 cycles after the strobe, held 600 cycles.
    cmd_valid = 2'b01; cmd = 4'b0001; wr_byte = 16'h00CC;
    tick();
    cmd_valid = '0;
    chk("wr.strobe", 32'(stb), 32'b010);
    chk("wr.inByte", 32'(ow_in_byte), 32'hCC);
    repeat (70) tick();
    chk("wr.heldBeforeBusy", 32'(ow_write), 32'd1);
    ow_busy = 1'b1;
    tick(); chk("wr.held1", 32'(ow_write), 32'd1);
    tick(); chk("wr.held2", 32'(ow_write), 32'd1);
    tick(); chk("wr.dropped", 32'(stb), 32'd0);
    chk("wr.readyWhileBusy", 32'(cmd_ready), 32'd0);
    repeat (597) tick();
    ow_busy = 1'b0;
    tick(); chk("wr.done1", 32'(done), 32'd0);
    tick(); chk("wr.done2", 32'(done), 32'd0);
    tick(); chk("wr.done3", 32'(done), 32'd0);
    tick(); chk("wr.done4", 32'(done), 32'd1);
    chk("wr.readyAtDone", 32'(cmd_ready), 32'd1);
    tick(); chk("wr.doneEnd", 32'(done), 32'd0);

    // Read returning 0x5A, then a write must leave rd_byte alone.
    doCmd(0, 2'd2, 8'h11, 5, 20, 8'h5A, 1'b0);
    chk("rd.value", 32'(rd_byte), 32'h5A);
    ow_out_byte = 8'hFF;
    doCmd(0, 2'd1, 8'h33, 3, 10, 8'hFF, 1'b0);
    chk("rd.retained", 32'(rd_byte), 32'h5A);

    // Engine never answers.
    doCmd(0, 2'd1, 8'h77, 0, 0, 8'h00, 1'b1);

    // Reset while waiting for the engine to finish a read.
    cmd_valid = 2'b01; cmd = 4'b0010;
    tick();
    cmd_valid = '0;
    repeat (3) tick();
    ow_busy = 1'b1; ow_out_byte = 8'hA5;
    repeat (10) tick();
    RST_N = 1'b0; ow_busy = 1'b0;
    tick();
    chkResetOutputs("midReset");
    RST_N = 1'b1; req = 2'b10;
    tick();
    chk("postReset.grant", 32'(grant), 32'b10);
    req = 2'b00;
    tick();
    chk("postReset.release", 32'(grant), 32'd0);
    rdModel = 8'h00;
    lastModel = 1;

    // Random transactions against a transaction-level model.
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(1, 3);
      exp = -1;
      for (int k = 1; k <= N && exp < 0; k++)
        if (r[(lastModel + k) % N]) exp = (lastModel + k) % N;
      req = 2'(r);
      own = 0;
      for (int i = 0; i < 5 && grant == '0; i++) tick();
      chk("rnd.grant", 32'(grant), 32'(1 << exp));
      for (int i = 0; i < N; i++) if (grant[i]) own = i;
      nCmd = $urandom_range(1, 2);
      for (int j = 0; j < nCmd; j++) begin
        c = 2'($urandom_range(0, 2));
        doCmd(own, c, 8'($urandom_range(0, 255)), $urandom_range(0, 30),
              $urandom_range(1, 40), 8'($urandom_range(0, 255)),
              $urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid[own] = 1'b1;
        cmd[2*own +: 2] = 2'd3;
        tick();
        cmd_valid = '0;
      end else begin
        req[own] = 1'b0;
        tick();
      end
      req = '0;
      chk("rnd.release", 32'(grant), 32'd0);
      tick();
      chk("rnd.idle", 32'(grant), 32'd0);
      lastModel = exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
